mem_wb_elastic_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 12 +
 rtl/wb_entry_reg.sv | 25 ++
 rtl/mem_wb_elastic_reg.sv | 78 +++++++
 tb/tb_mem_wb_elastic_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the MEM/WB boundary register.
package pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  typedef struct packed {
    logic                   wb_en;
    logic [RADDR_W_DEF-1:0] wb_addr;
    logic [XLEN_DEF-1:0]    wb_data;
  } wb_entry_t;
endpackage

// File: rtl/wb_entry_reg.sv
// wb_entry_reg: one held writeback entry; clear drops only the valid bit, reset zeroes everything.
module wb_entry_reg
  import pipe_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  T     d,
  output logic valid,
  output T     q
);
  always_ff @(posedge clk)
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
endmodule

// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg: MEM/WB elastic boundary with optional skid entry, flush and forwarding.
module mem_wb_elastic_reg
  import pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_memtoreg,
  input  logic               in_regwrite,
  input  logic [XLEN-1:0]    in_rdata,
  input  logic [XLEN-1:0]    in_alures,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_wb_en,
  output logic [RADDR_W-1:0] out_wb_addr,
  output logic [XLEN-1:0]    out_wb_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]    fwd_data,
  output logic [1:0]         occupancy
);
  typedef struct packed {
    logic               wb_en;
    logic [RADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]    wb_data;
  } entry_t;
  state_t state, nxt;
  entry_t cap, main_d, main_q, skid_q;
  logic main_v, skid_v, in_fire, out_fire, main_load, main_clear, skid_load, skid_clear, ready_q;
  assign cap = '{wb_en: in_regwrite & (in_rd != RADDR_W'(REG_ZERO)), wb_addr: in_rd,
                 wb_data: in_memtoreg ? in_rdata : in_alures};
  assign in_ready   = (SKID != 0) ? ready_q : (~main_v | out_ready);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_v & out_ready;
  // Main always holds the oldest entry: it refills from skid first, otherwise from the input.
  assign main_load  = skid_v ? out_fire : in_fire & (~main_v | out_fire);
  assign main_d     = skid_v ? skid_q : cap;
  assign main_clear = flush | (out_fire & ~main_load);
  assign skid_load  = (SKID != 0) & in_fire & main_v & ~out_fire;
  assign skid_clear = flush | out_fire;
  wb_entry_reg #(.T(entry_t)) u_main (
    .clk(clk), .reset(reset), .clear(main_clear), .load(main_load),
    .d(main_d), .valid(main_v), .q(main_q)
  );
  wb_entry_reg #(.T(entry_t)) u_skid (
    .clk(clk), .reset(reset), .clear(skid_clear), .load(skid_load),
    .d(cap), .valid(skid_v), .q(skid_q)
  );
  always_comb
    nxt = flush ? EMPTY :
          state == EMPTY ? (in_fire ? ONE : EMPTY) :
          state == ONE ? ((in_fire & ~out_fire) ? TWO : (out_fire & ~in_fire) ? EMPTY : ONE) :
          (out_fire ? ONE : TWO);
  always_ff @(posedge clk)
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= nxt;
      ready_q <= nxt != TWO;
    end
  assign occupancy   = state;
  assign out_valid   = main_v;
  assign out_wb_en   = main_v & main_q.wb_en;
  assign out_wb_addr = main_q.wb_addr;
  assign out_wb_data = main_q.wb_data;
  // Youngest producer wins when both entries are held.
  assign fwd_valid   = skid_v ? skid_q.wb_en : main_v & main_q.wb_en;
  assign fwd_addr    = skid_v ? skid_q.wb_addr : main_q.wb_addr;
  assign fwd_data    = skid_v ? skid_q.wb_data : main_q.wb_data;
endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// tb_mem_wb_elastic_reg: directed vectors and corner sequences for both skid configurations.
module tb_mem_wb_elastic_reg;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_memtoreg = 1'b0, in_regwrite = 1'b0, out_ready = 1'b0;
  logic [31:0] in_rdata = '0, in_alures = '0;
  logic [4:0] in_rd = '0;
  logic in_ready, out_valid, out_wb_en, fwd_valid;
  logic [4:0] out_wb_addr, fwd_addr;
  logic [31:0] out_wb_data, fwd_data;
  logic [1:0] occupancy;
  logic s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [4:0] s_in_rd = '0;
  logic [31:0] s_in_alures = '0;
  logic s_in_ready, s_out_valid, s_out_wb_en, s_fwd_valid;
  logic [4:0] s_out_wb_addr, s_fwd_addr;
  logic [31:0] s_out_wb_data, s_fwd_data;
  logic [1:0] s_occupancy;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_wb_elastic_reg #(.XLEN(32), .RADDR_W(5), .SKID(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_rdata(in_rdata),
    .in_alures(in_alures), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_wb_addr(out_wb_addr), .out_wb_data(out_wb_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .occupancy(occupancy)
  );
  mem_wb_elastic_reg #(.XLEN(32), .RADDR_W(5), .SKID(0)) u_s0 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_memtoreg(1'b0), .in_regwrite(1'b1), .in_rdata(32'h0),
    .in_alures(s_in_alures), .in_rd(s_in_rd), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_wb_en(s_out_wb_en), .out_wb_addr(s_out_wb_addr), .out_wb_data(s_out_wb_data),
    .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data), .occupancy(s_occupancy)
  );
  typedef struct {
    logic m, rw;
    logic [31:0] rdata, alu;
    logic [4:0] rd;
    logic en;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[5];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [4:0] rd, input logic [31:0] alu);
    in_valid = 1'b1; in_memtoreg = 1'b0; in_regwrite = 1'b1; in_rd = rd; in_alures = alu;
    step();
    in_valid = 1'b0;
  endtask
  initial begin
    vecs[0] = '{m: 1'b0, rw: 1'b1, rdata: 32'h0000_AAAA, alu: 32'h0000_1234, rd: 5'd7,  en: 1'b1, data: 32'h0000_1234};
    vecs[1] = '{m: 1'b1, rw: 1'b1, rdata: 32'hDEAD_BEEF, alu: 32'h0000_0010, rd: 5'd3,  en: 1'b1, data: 32'hDEAD_BEEF};
    vecs[2] = '{m: 1'b0, rw: 1'b1, rdata: 32'h0000_0000, alu: 32'h0000_0055, rd: 5'd0,  en: 1'b0, data: 32'h0000_0055};
    vecs[3] = '{m: 1'b1, rw: 1'b0, rdata: 32'h0000_CAFE, alu: 32'h0000_0001, rd: 5'd9,  en: 1'b0, data: 32'h0000_CAFE};
    vecs[4] = '{m: 1'b0, rw: 1'b1, rdata: 32'h1111_1111, alu: 32'hFFFF_FFFF, rd: 5'd31, en: 1'b1, data: 32'hFFFF_FFFF};
    step(); step();
    reset = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset occupancy", occupancy, 0);
    chk("reset fwd_valid", fwd_valid, 0);
    chk("reset wb_data", out_wb_data, 0);
    chk("reset s0 in_ready", s_in_ready, 1);
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_memtoreg = vecs[i].m; in_regwrite = vecs[i].rw;
      in_rdata = vecs[i].rdata; in_alures = vecs[i].alu; in_rd = vecs[i].rd;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d wb_en", i), out_wb_en, vecs[i].en);
      chk($sformatf("vec%0d wb_addr", i), out_wb_addr, vecs[i].rd);
      chk($sformatf("vec%0d wb_data", i), out_wb_data, vecs[i].data);
      chk($sformatf("vec%0d fwd_valid", i), fwd_valid, vecs[i].en);
      chk($sformatf("vec%0d fwd_addr", i), fwd_addr, vecs[i].rd);
      chk($sformatf("vec%0d occupancy", i), occupancy, 1);
      step();
      chk($sformatf("vec%0d drained", i), out_valid, 0);
    end
    // Back-to-back streaming through main with simultaneous in/out fire.
    in_valid = 1'b1; in_regwrite = 1'b1; in_memtoreg = 1'b0; in_rd = 5'd20; in_alures = 32'h20;
    step();
    chk("stream1 addr", out_wb_addr, 20);
    in_rd = 5'd21; in_alures = 32'h21;
    step();
    in_valid = 1'b0;
    chk("stream2 addr", out_wb_addr, 21);
    chk("stream2 occupancy", occupancy, 1);
    chk("stream2 in_ready", in_ready, 1);
    step();
    // Backpressure fills main then skid.
    out_ready = 1'b0;
    send(5'd1, 32'hA1);
    chk("bp one in_ready", in_ready, 1);
    send(5'd2, 32'hB2);
    chk("bp occupancy", occupancy, 2);
    chk("bp in_ready", in_ready, 0);
    chk("bp fwd_addr", fwd_addr, 2);
    chk("bp fwd_data", fwd_data, 32'hB2);
    chk("bp fwd_valid", fwd_valid, 1);
    chk("bp main addr", out_wb_addr, 1);
    in_valid = 1'b1; in_rd = 5'd13; in_alures = 32'hEE;
    step();
    in_valid = 1'b0;
    chk("bp ignored occ", occupancy, 2);
    chk("bp ignored fwd", fwd_addr, 2);
    out_ready = 1'b1;
    chk("drain A addr", out_wb_addr, 1);
    chk("drain A data", out_wb_data, 32'hA1);
    step();
    chk("drain B addr", out_wb_addr, 2);
    chk("drain B data", out_wb_data, 32'hB2);
    chk("drain B occ", occupancy, 1);
    chk("drain B in_ready", in_ready, 1);
    step();
    chk("drained valid", out_valid, 0);
    chk("drained wb_en", out_wb_en, 0);
    chk("drained data hold", out_wb_data, 32'hB2);
    chk("drained occ", occupancy, 0);
    // Flush with full buffer and incoming request.
    out_ready = 1'b0;
    send(5'd4, 32'h44);
    send(5'd5, 32'h55);
    in_valid = 1'b1; in_rd = 5'd6; in_alures = 32'h66; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2 occ", occupancy, 0);
    chk("flush2 out_valid", out_valid, 0);
    chk("flush2 in_ready", in_ready, 1);
    chk("flush2 data kept", out_wb_data, 32'h44);
    out_ready = 1'b1;
    step();
    chk("flush2 no ghost", out_valid, 0);
    // Flush in ONE must beat an accepted input.
    out_ready = 1'b0;
    send(5'd8, 32'h88);
    in_valid = 1'b1; in_rd = 5'd9; in_alures = 32'h99; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1 occ", occupancy, 0);
    chk("flush1 out_valid", out_valid, 0);
    step();
    chk("flush1 no ghost", out_valid, 0);
    // Reset mid-operation also zeroes data.
    send(5'd10, 32'hABCD);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset occ", occupancy, 0);
    chk("midreset data", out_wb_data, 0);
    chk("midreset addr", out_wb_addr, 0);
    chk("midreset in_ready", in_ready, 1);
    // Single-entry configuration.
    s_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_in_valid = 1'b1; s_in_rd = 5'(10 + k); s_in_alures = 32'(16 + k);
      step();
      chk($sformatf("s0 stream%0d valid", k), s_out_valid, 1);
      chk($sformatf("s0 stream%0d addr", k), s_out_wb_addr, 10 + k);
      chk($sformatf("s0 stream%0d in_ready", k), s_in_ready, 1);
    end
    s_out_ready = 1'b0;
    #1;
    chk("s0 comb stall", s_in_ready, 0);
    s_in_rd = 5'd15;
    step();
    chk("s0 held addr", s_out_wb_addr, 12);
    chk("s0 occupancy", s_occupancy, 1);
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    step();
    chk("s0 empty", s_out_valid, 0);
    s_out_ready = 1'b0;
    #1;
    chk("s0 empty ready", s_in_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
